// File: rtl/traffic_pkg.sv
// Shared types and helpers for the parametrised traffic controller.
package traffic_pkg;

   typedef enum logic [1:0] {
      StGreen,
      StYellow,
      StAllRed
   } state_e;

   // Per-approach lamp encoding {R,Y,G}
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   // Index of the lowest set bit; 0 when no bit is set (caller qualifies with a valid flag).
   function automatic int unsigned lowest_set_idx(input logic [31:0] v);
      int unsigned idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_dir_select.sv
// Combinational round-robin pick: first requested index after cur_i, wrapping mod NUM_DIRS.
module rr_dir_select
   import traffic_pkg::*;
#(
   parameter int unsigned NUM_DIRS = 4,
   parameter int unsigned DIR_W    = $clog2(NUM_DIRS)
) (
   input  logic [NUM_DIRS-1:0] req_i,
   input  logic [DIR_W-1:0]    cur_i,
   output logic [DIR_W-1:0]    idx_o,
   output logic                valid_o
);

   logic [2*NUM_DIRS-1:0] dbl;
   logic [NUM_DIRS-1:0]   rot;
   int unsigned           start;
   int unsigned           off;
   int unsigned           sum;

   always_comb begin
      dbl   = {req_i, req_i};
      start = 32'(cur_i) + 32'd1;
      if (start >= NUM_DIRS) start = 0;
      // Rotate so the search origin lands at bit 0, then take the lowest set bit.
      rot   = dbl[start +: NUM_DIRS];
      off   = lowest_set_idx(32'(rot));
      sum   = start + off;
      if (sum >= NUM_DIRS) sum = sum - NUM_DIRS;
      idx_o   = DIR_W'(sum);
      valid_o = |req_i;
   end

endmodule

// File: rtl/traffic_controller_n.sv
// Round-robin N-approach signal controller with demand skipping and emergency preemption.
module traffic_controller_n
   import traffic_pkg::*;
#(
   parameter int unsigned NUM_DIRS   = 4,
   parameter int unsigned GREEN_CYC  = 8,
   parameter int unsigned YELLOW_CYC = 3,
   parameter int unsigned ALLRED_CYC = 2,
   parameter int unsigned DIR_W      = $clog2(NUM_DIRS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_DIRS-1:0]   demand,
   input  logic [NUM_DIRS-1:0]   emergency,
   output logic [3*NUM_DIRS-1:0] lights,
   output logic [DIR_W-1:0]      active_dir,
   output logic                  preempt_active
);

   localparam int unsigned MAX_GY  = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
   localparam int unsigned MAX_DUR = (MAX_GY > ALLRED_CYC) ? MAX_GY : ALLRED_CYC;
   localparam int unsigned TMR_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

   localparam logic [TMR_W-1:0] GRN_LD = TMR_W'(GREEN_CYC - 1);
   localparam logic [TMR_W-1:0] YEL_LD = TMR_W'(YELLOW_CYC - 1);
   localparam logic [TMR_W-1:0] ALR_LD = TMR_W'(ALLRED_CYC - 1);

   localparam logic [3*NUM_DIRS-1:0] ALL_RED = {NUM_DIRS{LAMP_RED}};

   state_e                state_q, state_d;
   logic [TMR_W-1:0]      timer_q, timer_d;
   logic [DIR_W-1:0]      active_q, active_d;
   logic                  preempt_q, preempt_d;
   logic [3*NUM_DIRS-1:0] lights_q, lights_d;

   logic [DIR_W-1:0]    emg_idx, dmd_idx;
   logic                emg_valid, dmd_valid;
   logic [NUM_DIRS-1:0] act_oh;
   logic                other_demand;

   // Searching from the last index makes the round-robin picker return the lowest set bit.
   rr_dir_select #(
      .NUM_DIRS (NUM_DIRS),
      .DIR_W    (DIR_W)
   ) u_emg_sel (
      .req_i   (emergency),
      .cur_i   (DIR_W'(NUM_DIRS - 1)),
      .idx_o   (emg_idx),
      .valid_o (emg_valid)
   );

   rr_dir_select #(
      .NUM_DIRS (NUM_DIRS),
      .DIR_W    (DIR_W)
   ) u_dmd_sel (
      .req_i   (demand),
      .cur_i   (active_q),
      .idx_o   (dmd_idx),
      .valid_o (dmd_valid)
   );

   always_comb begin
      act_oh           = '0;
      act_oh[active_q] = 1'b1;
      other_demand     = |(demand & ~act_oh);
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      active_d  = active_q;
      preempt_d = preempt_q;
      unique case (state_q)
         StGreen: begin
            if (emg_valid && (emg_idx != active_q)) begin
               state_d   = StYellow;
               timer_d   = YEL_LD;
               preempt_d = 1'b1;
            end else if (emg_valid) begin
               preempt_d = 1'b1;
            end else begin
               preempt_d = 1'b0;
               if (timer_q != '0) begin
                  timer_d = timer_q - TMR_W'(1);
               end else if (other_demand) begin
                  state_d = StYellow;
                  timer_d = YEL_LD;
               end
            end
         end
         StYellow: begin
            if (timer_q == '0) begin
               state_d = StAllRed;
               timer_d = ALR_LD;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         StAllRed: begin
            if (timer_q == '0) begin
               state_d = StGreen;
               timer_d = GRN_LD;
               if (emg_valid) begin
                  active_d  = emg_idx;
                  preempt_d = 1'b1;
               end else if (dmd_valid) begin
                  active_d  = dmd_idx;
                  preempt_d = 1'b0;
               end else begin
                  active_d  = (32'(active_q) + 32'd1 >= NUM_DIRS) ? '0 : active_q + DIR_W'(1);
                  preempt_d = 1'b0;
               end
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         default: begin
            state_d = StAllRed;
            timer_d = ALR_LD;
         end
      endcase
   end

   // Lamps are registered from next state so outputs carry no input-to-output path.
   always_comb begin
      lights_d = ALL_RED;
      for (int d = 0; d < NUM_DIRS; d++) begin
         if (active_d == DIR_W'(d)) begin
            if (state_d == StGreen)       lights_d[3*d +: 3] = LAMP_GRN;
            else if (state_d == StYellow) lights_d[3*d +: 3] = LAMP_YEL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StAllRed;
         timer_q   <= ALR_LD;
         active_q  <= DIR_W'(NUM_DIRS - 1);
         preempt_q <= 1'b0;
         lights_q  <= ALL_RED;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         active_q  <= active_d;
         preempt_q <= preempt_d;
         lights_q  <= lights_d;
      end
   end

   assign lights         = lights_q;
   assign active_dir     = active_q;
   assign preempt_active = preempt_q;

endmodule

// File: tb/tb_traffic_controller_n.sv
// Directed bench for traffic_controller_n at NUM_DIRS=4, GREEN=8, YELLOW=3, ALLRED=2.
module tb_traffic_controller_n;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  demand;
   logic [3:0]  emergency;
   logic [11:0] lights;
   logic [1:0]  active_dir;
   logic        preempt_active;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   traffic_controller_n #(
      .NUM_DIRS   (4),
      .GREEN_CYC  (8),
      .YELLOW_CYC (3),
      .ALLRED_CYC (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .demand         (demand),
      .emergency      (emergency),
      .lights         (lights),
      .active_dir     (active_dir),
      .preempt_active (preempt_active)
   );

   // Expected lamp word: ph 0 = green, 1 = yellow, 2 = all red.
   function automatic logic [11:0] lamps(input int ph, input int dir);
      logic [11:0] v;
      v = 12'h924;
      if (ph == 0)      v[3*dir +: 3] = 3'b001;
      else if (ph == 1) v[3*dir +: 3] = 3'b010;
      return v;
   endfunction

   // Outputs are observed at the falling edge after each rising edge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Leaves the DUT at the first observed cycle of the first green.
   task automatic do_reset(input logic [3:0] d);
      reset = 1'b1; demand = d; emergency = 4'b0000;
      tick(2);
      reset = 1'b0;
      tick(2);
   endtask

   task automatic test_reset();
      reset = 1'b1; demand = 4'b1111; emergency = 4'b0000;
      tick(2);
      total++; if (lights !== 12'h924)
         begin bad++; $display("FAIL reset_lights got=%h exp=924", lights); end
      total++; if (active_dir !== 2'd3)
         begin bad++; $display("FAIL reset_dir got=%0d exp=3", active_dir); end
      total++; if (preempt_active !== 1'b0)
         begin bad++; $display("FAIL reset_preempt got=%b exp=0", preempt_active); end
      reset = 1'b0;
      tick();
      total++; if (lights !== 12'h924)
         begin bad++; $display("FAIL reset_allred2 got=%h exp=924", lights); end
      total++; if (active_dir !== 2'd3)
         begin bad++; $display("FAIL reset_allred2_dir got=%0d exp=3", active_dir); end
      tick();
      total++; if (lights !== lamps(0, 0))
         begin bad++; $display("FAIL reset_first_green got=%h exp=%h", lights, lamps(0, 0)); end
      total++; if (active_dir !== 2'd0)
         begin bad++; $display("FAIL reset_first_dir got=%0d exp=0", active_dir); end
   endtask

   // Full demand: 13-cycle period per approach, 0,1,2,3,0 including wrap.
   task automatic test_round_robin();
      int dir, pos, ph;
      do_reset(4'b1111);
      for (int k = 0; k < 65; k++) begin
         dir = (k / 13) % 4;
         pos = k % 13;
         ph  = (pos < 8) ? 0 : (pos < 11) ? 1 : 2;
         total++; if (lights !== lamps(ph, dir))
            begin bad++; $display("FAIL rr_lights k=%0d got=%h exp=%h", k, lights, lamps(ph, dir)); end
         total++; if (active_dir !== 2'(dir))
            begin bad++; $display("FAIL rr_dir k=%0d got=%0d exp=%0d", k, active_dir, dir); end
         tick();
      end
   endtask

   // Demand on 0 and 2 only: greens alternate 0,2,0 and 1,3 stay red throughout.
   task automatic test_sparse_demand();
      int dir, pos, ph;
      do_reset(4'b0101);
      for (int k = 0; k < 39; k++) begin
         dir = ((k / 13) % 2 == 0) ? 0 : 2;
         pos = k % 13;
         ph  = (pos < 8) ? 0 : (pos < 11) ? 1 : 2;
         total++; if (lights !== lamps(ph, dir))
            begin bad++; $display("FAIL sparse_lights k=%0d got=%h exp=%h", k, lights, lamps(ph, dir)); end
         tick();
      end
   endtask

   task automatic test_rest_green();
      do_reset(4'b0001);
      tick(20);
      total++; if (lights !== lamps(0, 0))
         begin bad++; $display("FAIL rest_lights got=%h exp=%h", lights, lamps(0, 0)); end
      total++; if (active_dir !== 2'd0)
         begin bad++; $display("FAIL rest_dir got=%0d exp=0", active_dir); end
      demand = 4'b1001;
      tick();
      total++; if (lights !== lamps(1, 0))
         begin bad++; $display("FAIL rest_to_yellow got=%h exp=%h", lights, lamps(1, 0)); end
      tick(5);
      total++; if (lights !== lamps(0, 3))
         begin bad++; $display("FAIL rest_next_dir got=%h exp=%h", lights, lamps(0, 3)); end
   endtask

   task automatic test_emergency_pulse();
      do_reset(4'b1111);
      tick(2);
      emergency = 4'b0100;
      tick();
      emergency = 4'b0000;
      total++; if (lights !== lamps(1, 0))
         begin bad++; $display("FAIL pulse_yellow got=%h exp=%h", lights, lamps(1, 0)); end
      total++; if (preempt_active !== 1'b1)
         begin bad++; $display("FAIL pulse_preempt got=%b exp=1", preempt_active); end
      tick(2);
      total++; if (lights !== lamps(1, 0))
         begin bad++; $display("FAIL pulse_yellow_full got=%h exp=%h", lights, lamps(1, 0)); end
      tick();
      total++; if (lights !== 12'h924)
         begin bad++; $display("FAIL pulse_allred got=%h exp=924", lights); end
      tick(2);
      total++; if (lights !== lamps(0, 1))
         begin bad++; $display("FAIL pulse_fallback got=%h exp=%h", lights, lamps(0, 1)); end
      total++; if (preempt_active !== 1'b0)
         begin bad++; $display("FAIL pulse_preempt_clr got=%b exp=0", preempt_active); end
   endtask

   task automatic test_emergency_hold();
      do_reset(4'b1111);
      tick(2);
      emergency = 4'b0100;
      tick(6);
      total++; if (lights !== lamps(0, 2))
         begin bad++; $display("FAIL hold_green got=%h exp=%h", lights, lamps(0, 2)); end
      total++; if (preempt_active !== 1'b1)
         begin bad++; $display("FAIL hold_preempt got=%b exp=1", preempt_active); end
      tick(20);
      total++; if (lights !== lamps(0, 2))
         begin bad++; $display("FAIL hold_long got=%h exp=%h", lights, lamps(0, 2)); end
      emergency = 4'b0000;
      tick();
      total++; if (preempt_active !== 1'b0)
         begin bad++; $display("FAIL hold_release_preempt got=%b exp=0", preempt_active); end
      tick(6);
      total++; if (lights !== lamps(0, 2))
         begin bad++; $display("FAIL hold_timer_frozen got=%h exp=%h", lights, lamps(0, 2)); end
      tick();
      total++; if (lights !== lamps(1, 2))
         begin bad++; $display("FAIL hold_release_yellow got=%h exp=%h", lights, lamps(1, 2)); end
   endtask

   task automatic test_emergency_priority();
      do_reset(4'b1111);
      emergency = 4'b0110;
      tick(6);
      total++; if (lights !== lamps(0, 1))
         begin bad++; $display("FAIL prio_dir1 got=%h exp=%h", lights, lamps(0, 1)); end
      total++; if (active_dir !== 2'd1)
         begin bad++; $display("FAIL prio_dir1_idx got=%0d exp=1", active_dir); end
      emergency = 4'b0100;
      tick();
      total++; if (lights !== lamps(1, 1))
         begin bad++; $display("FAIL prio_dir1_yellow got=%h exp=%h", lights, lamps(1, 1)); end
      tick(5);
      total++; if (lights !== lamps(0, 2))
         begin bad++; $display("FAIL prio_dir2 got=%h exp=%h", lights, lamps(0, 2)); end
      total++; if (preempt_active !== 1'b1)
         begin bad++; $display("FAIL prio_dir2_preempt got=%b exp=1", preempt_active); end
      emergency = 4'b0101;
      tick();
      total++; if (lights !== lamps(1, 2))
         begin bad++; $display("FAIL prio_higher_preempts got=%h exp=%h", lights, lamps(1, 2)); end
      tick(5);
      total++; if (active_dir !== 2'd0)
         begin bad++; $display("FAIL prio_dir0_idx got=%0d exp=0", active_dir); end
      emergency = 4'b0000;
   endtask

   task automatic test_reset_mid_yellow();
      do_reset(4'b1111);
      emergency = 4'b0010;
      tick();
      emergency = 4'b0000;
      tick();
      total++; if (preempt_active !== 1'b1)
         begin bad++; $display("FAIL midy_pre_preempt got=%b exp=1", preempt_active); end
      reset = 1'b1;
      tick();
      total++; if (lights !== 12'h924)
         begin bad++; $display("FAIL midy_lights got=%h exp=924", lights); end
      total++; if (active_dir !== 2'd3)
         begin bad++; $display("FAIL midy_dir got=%0d exp=3", active_dir); end
      total++; if (preempt_active !== 1'b0)
         begin bad++; $display("FAIL midy_preempt got=%b exp=0", preempt_active); end
      reset = 1'b0;
      tick();
      total++; if (lights !== 12'h924)
         begin bad++; $display("FAIL midy_allred got=%h exp=924", lights); end
      tick();
      total++; if (lights !== lamps(0, 0))
         begin bad++; $display("FAIL midy_restart got=%h exp=%h", lights, lamps(0, 0)); end
   endtask

   initial begin
      reset = 1'b1; demand = 4'b0000; emergency = 4'b0000;
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_sparse_demand();
      test_rest_green();
      test_emergency_pulse();
      test_emergency_hold();
      test_emergency_priority();
      test_reset_mid_yellow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
